// File: rtl/alarm_responder.sv
// Alarm response FSM: rings the buzzer 1 s on / 1 s off, handles stop, timeout and snooze.
// Snooze support is built only when ALARM_SNOOZE_EN is defined; otherwise snooze outputs stay 0.
module alarm_responder #(
  parameter int SNOOZE_MIN   = 9,
  parameter int RING_TIMEOUT = 60,
  parameter int MAX_SNOOZE   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       buzz_req,
  input  logic       alarm_on,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  input  logic [6:0] tmin,
  input  logic [6:0] thrs,
  output logic       buzz,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] snooze_cnt,
  output logic [6:0] snz_min,
  output logic [6:0] snz_hrs
);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE, DONE} state_e;

  state_e     state_q, state_d;
  logic [6:0] ring_cnt_q, ring_cnt_d;
  logic       buzz_q, buzz_d;
  logic       ringing_q, snoozing_q;
  logic       buzz_req_q;
  logic [1:0] snz_cnt_q, snz_cnt_d;
  logic [6:0] snz_min_q, snz_min_d;
  logic [6:0] snz_hrs_q, snz_hrs_d;
  logic       snz_lock_q, snz_lock_d;

  logic       req_rise;
  logic       snooze_acc;
  logic       wake;
  logic [6:0] min_sum;

  assign req_rise = buzz_req & ~buzz_req_q;
  assign min_sum  = tmin + 7'(SNOOZE_MIN);

`ifdef ALARM_SNOOZE_EN
  // A held button is locked out after one accepted snooze until it is released.
  assign snooze_acc = snooze_btn && !snz_lock_q && (snz_cnt_q < 2'(MAX_SNOOZE));
  assign wake       = (tmin == snz_min_q) && (thrs == snz_hrs_q);
`else
  assign snooze_acc = 1'b0;
  assign wake       = 1'b0;
`endif

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    buzz_d     = 1'b0;
    snz_cnt_d  = snz_cnt_q;
    snz_min_d  = snz_min_q;
    snz_hrs_d  = snz_hrs_q;
    snz_lock_d = snz_lock_q & snooze_btn;
    unique case (state_q)
      IDLE: begin
        if (req_rise) begin
          if (alarm_on) begin
            state_d    = RING;
            ring_cnt_d = '0;
            buzz_d     = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      RING: begin
        ring_cnt_d = ring_cnt_q + 7'd1;
        if (!alarm_on || stop_btn) begin
          state_d = DONE;
        end else if (snooze_acc) begin
          state_d    = SNOOZE;
          snz_cnt_d  = snz_cnt_q + 2'd1;
          snz_lock_d = 1'b1;
          if (min_sum >= 7'd60) begin
            snz_min_d = min_sum - 7'd60;
            snz_hrs_d = (thrs == 7'd23) ? 7'd0 : thrs + 7'd1;
          end else begin
            snz_min_d = min_sum;
            snz_hrs_d = thrs;
          end
        end else if (ring_cnt_q == 7'(RING_TIMEOUT - 1)) begin
          state_d = DONE;
        end else begin
          buzz_d = ~ring_cnt_d[0];
        end
      end
      SNOOZE: begin
        if (!alarm_on || stop_btn) begin
          state_d = DONE;
        end else if (wake) begin
          state_d    = RING;
          ring_cnt_d = '0;
          buzz_d     = 1'b1;
        end
      end
      DONE: begin
        if (!buzz_req) begin
          state_d   = IDLE;
          snz_cnt_d = '0;
          snz_min_d = '0;
          snz_hrs_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      buzz_q     <= 1'b0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
      buzz_req_q <= 1'b0;
      snz_cnt_q  <= '0;
      snz_min_q  <= '0;
      snz_hrs_q  <= '0;
      snz_lock_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      buzz_q     <= buzz_d;
      ringing_q  <= (state_d == RING);
      snoozing_q <= (state_d == SNOOZE);
      buzz_req_q <= buzz_req;
      snz_cnt_q  <= snz_cnt_d;
      snz_min_q  <= snz_min_d;
      snz_hrs_q  <= snz_hrs_d;
      snz_lock_q <= snz_lock_d;
    end
  end

  assign buzz       = buzz_q;
  assign ringing    = ringing_q;
  assign snoozing   = snoozing_q;
  assign snooze_cnt = snz_cnt_q;
  assign snz_min    = snz_min_q;
  assign snz_hrs    = snz_hrs_q;

endmodule

// File: tb/tb_alarm_responder.sv
// Self-checking bench for alarm_responder: vector table plus hand-written ring/snooze/reset sequences.
// Snooze sequences run when ALARM_SNOOZE_EN is defined; otherwise the button is checked to be ignored.
module tb_alarm_responder;

  typedef struct packed {
    logic       buzz;
    logic       ringing;
    logic       snoozing;
    logic [1:0] scnt;
    logic [6:0] smin;
    logic [6:0] shrs;
  } exp_t;

  typedef struct {
    logic       br;
    logic       ao;
    logic       sn;
    logic       st;
    logic [6:0] mn;
    logic [6:0] hr;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       buzz_req = 1'b0;
  logic       alarm_on = 1'b1;
  logic       snooze_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic [6:0] tmin = 7'd0;
  logic [6:0] thrs = 7'd7;
  logic       buzz, ringing, snoozing;
  logic [1:0] snooze_cnt;
  logic [6:0] snz_min, snz_hrs;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t  sb_q[$];
  string nm_q[$];
  vec_t  tbl[11];

  alarm_responder dut (
    .clk        (clk),
    .rst        (rst),
    .buzz_req   (buzz_req),
    .alarm_on   (alarm_on),
    .snooze_btn (snooze_btn),
    .stop_btn   (stop_btn),
    .tmin       (tmin),
    .thrs       (thrs),
    .buzz       (buzz),
    .ringing    (ringing),
    .snoozing   (snoozing),
    .snooze_cnt (snooze_cnt),
    .snz_min    (snz_min),
    .snz_hrs    (snz_hrs)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic b, input logic r, input logic s,
                              input logic [1:0] c, input logic [6:0] m, input logic [6:0] h);
    exp_t e;
    e = '{b, r, s, c, m, h};
    return e;
  endfunction

  function automatic exp_t cur();
    return mk(buzz, ringing, snoozing, snooze_cnt, snz_min, snz_hrs);
  endfunction

  task automatic check(input string nm, input exp_t act, input exp_t exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got buzz=%b ring=%b snz=%b cnt=%0d wake=%0d:%0d, expected buzz=%b ring=%b snz=%b cnt=%0d wake=%0d:%0d",
               nm, act.buzz, act.ringing, act.snoozing, act.scnt, act.shrs, act.smin,
               exp.buzz, exp.ringing, exp.snoozing, exp.scnt, exp.shrs, exp.smin);
    else
      n_pass++;
  endtask

  // Drive one cycle of inputs at the falling edge, expect the result just after the rising edge.
  task automatic cyc(input string nm, input logic br, input logic ao, input logic sn, input logic st,
                     input logic [6:0] mn, input logic [6:0] hr, input exp_t e);
    @(negedge clk);
    buzz_req   = br;
    alarm_on   = ao;
    snooze_btn = sn;
    stop_btn   = st;
    tmin       = mn;
    thrs       = hr;
    sb_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
    check(nm_q.pop_front(), cur(), sb_q.pop_front());
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear without a clock.
  task automatic rst_pulse(input string nm);
    #2 rst = 1'b1;
    #1 check(nm, cur(), mk(0, 0, 0, 2'd0, 7'd0, 7'd0));
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2 ms");
    $fatal(1);
  end

  initial begin
    exp_t z;
    exp_t r1;
    z  = mk(0, 0, 0, 2'd0, 7'd0, 7'd0);
    r1 = mk(1, 1, 0, 2'd0, 7'd0, 7'd0);

    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7'd59, 7'd6, z};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'd0,  7'd7, z};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 7'd0,  7'd7, z};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7'd1,  7'd7, z};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 7'd2,  7'd7, r1};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 7'd2,  7'd7, z};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 7'd2,  7'd7, z};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7'd3,  7'd7, z};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 7'd4,  7'd7, r1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'd4,  7'd7, z};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 7'd5,  7'd7, z};

    #1 rst = 1'b1;
    #1 check("reset_state", cur(), z);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++)
      cyc($sformatf("vec[%0d]", i), tbl[i].br, tbl[i].ao, tbl[i].sn, tbl[i].st,
          tbl[i].mn, tbl[i].hr, tbl[i].e);

    // Full ring at 07:00: alternating buzz for the whole timeout, then DONE until the request drops.
    for (int k = 0; k < 60; k++)
      cyc($sformatf("ring07_edge%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 7'd7,
          mk((k % 2) == 0, 1, 0, 2'd0, 7'd0, 7'd0));
    cyc("ring07_timeout", 1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 7'd7, z);
    cyc("ring07_done_hold", 1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 7'd7, z);
    cyc("ring07_idle", 1'b0, 1'b1, 1'b0, 1'b0, 7'd1, 7'd7, z);
    cyc("ring07_rearm", 1'b1, 1'b1, 1'b0, 1'b0, 7'd1, 7'd7, r1);
    cyc("ring07_stop", 1'b1, 1'b1, 1'b0, 1'b1, 7'd1, 7'd7, z);
    cyc("ring07_release", 1'b0, 1'b1, 1'b0, 1'b0, 7'd2, 7'd7, z);

    // Reset mid-ring with the request held: the event restarts at the first edge after release.
    cyc("rst_ring_a", 1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 7'd8, r1);
    cyc("rst_ring_b", 1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 7'd8, mk(0, 1, 0, 2'd0, 7'd0, 7'd0));
    cyc("rst_ring_c", 1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 7'd8, r1);
    rst_pulse("rst_ring_async");
    cyc("rst_ring_reenter", 1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 7'd8, r1);
    cyc("rst_ring_stop", 1'b1, 1'b1, 1'b0, 1'b1, 7'd0, 7'd8, z);
    cyc("rst_ring_idle", 1'b0, 1'b1, 1'b0, 1'b0, 7'd1, 7'd8, z);

`ifdef ALARM_SNOOZE_EN
    // 06:55 ring, snooze three times (one held press), fourth press ignored, then stop.
    cyc("s655_ring", 1'b1, 1'b1, 1'b0, 1'b0, 7'd55, 7'd6, r1);
    cyc("s655_e1", 1'b1, 1'b1, 1'b0, 1'b0, 7'd55, 7'd6, mk(0, 1, 0, 2'd0, 7'd0, 7'd0));
    cyc("s655_e2", 1'b1, 1'b1, 1'b0, 1'b0, 7'd55, 7'd6, r1);
    cyc("s655_snooze1", 1'b1, 1'b1, 1'b1, 1'b0, 7'd55, 7'd6, mk(0, 0, 1, 2'd1, 7'd4, 7'd7));
    cyc("s655_wait", 1'b0, 1'b1, 1'b0, 1'b0, 7'd56, 7'd6, mk(0, 0, 1, 2'd1, 7'd4, 7'd7));
    cyc("s655_wake1", 1'b0, 1'b1, 1'b0, 1'b0, 7'd4, 7'd7, mk(1, 1, 0, 2'd1, 7'd4, 7'd7));
    cyc("s655_snooze2", 1'b0, 1'b1, 1'b1, 1'b0, 7'd4, 7'd7, mk(0, 0, 1, 2'd2, 7'd13, 7'd7));
    cyc("s655_held", 1'b0, 1'b1, 1'b1, 1'b0, 7'd5, 7'd7, mk(0, 0, 1, 2'd2, 7'd13, 7'd7));
    cyc("s655_wake2_held", 1'b0, 1'b1, 1'b1, 1'b0, 7'd13, 7'd7, mk(1, 1, 0, 2'd2, 7'd13, 7'd7));
    cyc("s655_held_ignored", 1'b0, 1'b1, 1'b1, 1'b0, 7'd13, 7'd7, mk(0, 1, 0, 2'd2, 7'd13, 7'd7));
    cyc("s655_release", 1'b0, 1'b1, 1'b0, 1'b0, 7'd13, 7'd7, mk(1, 1, 0, 2'd2, 7'd13, 7'd7));
    cyc("s655_snooze3", 1'b0, 1'b1, 1'b1, 1'b0, 7'd13, 7'd7, mk(0, 0, 1, 2'd3, 7'd22, 7'd7));
    cyc("s655_wake3", 1'b0, 1'b1, 1'b0, 1'b0, 7'd22, 7'd7, mk(1, 1, 0, 2'd3, 7'd22, 7'd7));
    cyc("s655_ring3", 1'b0, 1'b1, 1'b0, 1'b0, 7'd22, 7'd7, mk(0, 1, 0, 2'd3, 7'd22, 7'd7));
    cyc("s655_snooze4_ign", 1'b0, 1'b1, 1'b1, 1'b0, 7'd22, 7'd7, mk(1, 1, 0, 2'd3, 7'd22, 7'd7));
    cyc("s655_stop", 1'b0, 1'b1, 1'b0, 1'b1, 7'd22, 7'd7, mk(0, 0, 0, 2'd3, 7'd22, 7'd7));
    cyc("s655_idle_clear", 1'b0, 1'b1, 1'b0, 1'b0, 7'd23, 7'd7, z);

    // 23:55 ring: snooze wraps to 00:04; stop beats a matching wake time.
    cyc("s2355_ring", 1'b1, 1'b1, 1'b0, 1'b0, 7'd55, 7'd23, r1);
    cyc("s2355_snooze1", 1'b1, 1'b1, 1'b1, 1'b0, 7'd55, 7'd23, mk(0, 0, 1, 2'd1, 7'd4, 7'd0));
    cyc("s2355_wait", 1'b0, 1'b1, 1'b0, 1'b0, 7'd59, 7'd23, mk(0, 0, 1, 2'd1, 7'd4, 7'd0));
    cyc("s2355_wake", 1'b0, 1'b1, 1'b0, 1'b0, 7'd4, 7'd0, mk(1, 1, 0, 2'd1, 7'd4, 7'd0));
    cyc("s2355_snooze2", 1'b0, 1'b1, 1'b1, 1'b0, 7'd4, 7'd0, mk(0, 0, 1, 2'd2, 7'd13, 7'd0));
    cyc("s2355_stop_vs_wake", 1'b0, 1'b1, 1'b0, 1'b1, 7'd13, 7'd0, mk(0, 0, 0, 2'd2, 7'd13, 7'd0));
    cyc("s2355_idle", 1'b0, 1'b1, 1'b0, 1'b0, 7'd14, 7'd0, z);

    // Stop and snooze on the same edge: stop wins, no snooze counted.
    cyc("s1050_ring", 1'b1, 1'b1, 1'b0, 1'b0, 7'd50, 7'd10, r1);
    cyc("s1050_stop_snooze", 1'b1, 1'b1, 1'b1, 1'b1, 7'd50, 7'd10, z);
    cyc("s1050_idle", 1'b0, 1'b1, 1'b0, 1'b0, 7'd51, 7'd10, z);

    // 10:51 + 9 lands exactly on 11:00; switching the alarm off in SNOOZE ends the event.
    cyc("s1051_ring", 1'b1, 1'b1, 1'b0, 1'b0, 7'd51, 7'd10, r1);
    cyc("s1051_snooze", 1'b1, 1'b1, 1'b1, 1'b0, 7'd51, 7'd10, mk(0, 0, 1, 2'd1, 7'd0, 7'd11));
    cyc("s1051_alarm_off", 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd11, mk(0, 0, 0, 2'd1, 7'd0, 7'd11));
    cyc("s1051_idle", 1'b0, 1'b1, 1'b0, 1'b0, 7'd1, 7'd11, z);

    // Reset mid-snooze discards the event; the held request re-rings with a fresh count.
    cyc("rst_snz_ring", 1'b1, 1'b1, 1'b0, 1'b0, 7'd55, 7'd6, r1);
    cyc("rst_snz_snooze", 1'b1, 1'b1, 1'b1, 1'b0, 7'd55, 7'd6, mk(0, 0, 1, 2'd1, 7'd4, 7'd7));
    rst_pulse("rst_snz_async");
    cyc("rst_snz_reenter", 1'b1, 1'b1, 1'b0, 1'b0, 7'd55, 7'd6, r1);
    cyc("rst_snz_stop", 1'b1, 1'b1, 1'b0, 1'b1, 7'd55, 7'd6, z);
    cyc("rst_snz_idle", 1'b0, 1'b1, 1'b0, 1'b0, 7'd56, 7'd6, z);
`else
    // Without snooze support the button must not interrupt ringing.
    cyc("nosnz_ring", 1'b1, 1'b1, 1'b0, 1'b0, 7'd55, 7'd6, r1);
    cyc("nosnz_press", 1'b1, 1'b1, 1'b1, 1'b0, 7'd55, 7'd6, mk(0, 1, 0, 2'd0, 7'd0, 7'd0));
    cyc("nosnz_held", 1'b1, 1'b1, 1'b1, 1'b0, 7'd55, 7'd6, r1);
    cyc("nosnz_stop", 1'b1, 1'b1, 1'b1, 1'b1, 7'd55, 7'd6, z);
    cyc("nosnz_idle", 1'b0, 1'b1, 1'b0, 1'b0, 7'd56, 7'd6, z);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
